branch_predictor_gshare: RTL and testbench

Parametrised gshare branch predictor with a direct-mapped BTB and an optional return-address stack. Fetch gets a same-cycle taken/target prediction from `i_pc_f`. Execute returns the resolved outcome, and the block updates its tables and flags mispredictions. It replaces the fixed 4-entry, PC-indexed predictor between the address generator (IF) and the hazard unit (EX flush/redirect).

---
 rtl/branch_predictor_gshare.sv | 170 +++++++++++++++++
 tb/tb_branch_predictor_gshare.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_gshare.sv
// Gshare direction predictor with a direct-mapped BTB, resolved non-speculatively from EX.
// Define BP_RAS_EN to add a return-address stack that supplies targets for BTB entries typed as returns.
module branch_predictor_gshare #(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16,
  parameter int BHT_ENTRIES = 64,
  parameter int GHR_BITS    = 4,
  parameter int RAS_DEPTH   = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [XLEN-1:0]                i_pc_f,
  output logic                           o_pred_taken,
  output logic [XLEN-1:0]                o_pred_target,
  output logic [$clog2(BHT_ENTRIES)-1:0] o_bht_idx_f,
  input  logic                           i_vld_e,
  input  logic [XLEN-1:0]                i_pc_e,
  input  logic [XLEN-1:0]                i_pc_four_e,
  input  logic                           i_is_branch_e,
  input  logic                           i_is_jump_e,
  input  logic                           i_is_call_e,
  input  logic                           i_is_ret_e,
  input  logic                           i_taken_e,
  input  logic [XLEN-1:0]                i_target_e,
  input  logic                           i_pred_taken_e,
  input  logic [XLEN-1:0]                i_pred_target_e,
  input  logic [$clog2(BHT_ENTRIES)-1:0] i_bht_idx_e,
  output logic                           o_mispredict,
  output logic [XLEN-1:0]                o_redirect_pc
);

  localparam int BTB_IDX_W = $clog2(BTB_ENTRIES);
  localparam int BHT_IDX_W = $clog2(BHT_ENTRIES);
  localparam int TAG_W     = XLEN - 2 - BTB_IDX_W;

  localparam logic [1:0] TYPE_BRANCH = 2'b00;
  localparam logic [1:0] TYPE_JUMP   = 2'b01;
  localparam logic [1:0] TYPE_CALL   = 2'b10;
  localparam logic [1:0] TYPE_RET    = 2'b11;

  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
    if (up) return (cnt == 2'b11) ? cnt : cnt + 2'b01;
    else    return (cnt == 2'b00) ? cnt : cnt - 2'b01;
  endfunction

  logic [BTB_ENTRIES-1:0]      btb_valid;
  logic [TAG_W-1:0]            btb_tag    [BTB_ENTRIES];
  logic [XLEN-1:0]             btb_target [BTB_ENTRIES];
  logic [1:0]                  btb_type   [BTB_ENTRIES];
  logic [BHT_ENTRIES-1:0][1:0] bht;
  logic [GHR_BITS-1:0]         ghr;

  logic [BTB_IDX_W-1:0] f_btb_idx;
  logic [TAG_W-1:0]     f_tag;
  logic [BHT_IDX_W-1:0] f_bht_idx;
  logic [1:0]           f_type;
  logic [1:0]           f_cnt;
  logic                 f_hit;
  logic                 f_taken;
  logic [XLEN-1:0]      f_target;
  logic [XLEN-1:0]      f_pc_plus4;

  logic [BTB_IDX_W-1:0] e_btb_idx;
  logic [TAG_W-1:0]     e_tag;
  logic                 e_branch_upd;
  logic                 e_btb_wr;
  logic [1:0]           e_jump_type;
  logic [1:0]           e_wr_type;
  logic                 unused_bits;

  // Fetch-side lookup
  assign f_btb_idx  = i_pc_f[2 +: BTB_IDX_W];
  assign f_tag      = i_pc_f[XLEN-1 -: TAG_W];
  assign f_bht_idx  = i_pc_f[2 +: BHT_IDX_W] ^ BHT_IDX_W'(ghr);
  assign f_type     = btb_type[f_btb_idx];
  assign f_cnt      = bht[f_bht_idx];
  assign f_hit      = btb_valid[f_btb_idx] && (btb_tag[f_btb_idx] == f_tag);
  assign f_taken    = f_hit && ((f_type != TYPE_BRANCH) || f_cnt[1]);
  assign f_pc_plus4 = i_pc_f + XLEN'(4);

  // Resolve-side decode
  assign e_btb_idx    = i_pc_e[2 +: BTB_IDX_W];
  assign e_tag        = i_pc_e[XLEN-1 -: TAG_W];
  assign e_branch_upd = i_vld_e & i_is_branch_e;
  assign e_btb_wr     = i_vld_e & ((i_is_branch_e & i_taken_e) | i_is_jump_e);
  assign e_wr_type    = i_is_jump_e ? e_jump_type : TYPE_BRANCH;

`ifdef BP_RAS_EN
  localparam int RAS_W = $clog2(RAS_DEPTH);

  logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
  logic [RAS_W-1:0] ras_ptr;
  logic [RAS_W:0]   ras_cnt;
  logic [RAS_W-1:0] ras_top_idx;
  logic [RAS_W-1:0] ras_wr_idx;
  logic             ras_push;
  logic             ras_pop;

  assign ras_top_idx = ras_ptr - RAS_W'(1);
  assign ras_push    = i_vld_e & i_is_call_e;
  assign ras_pop     = i_vld_e & i_is_ret_e & (ras_cnt != '0);
  // A simultaneous pop+push replaces the current top in place.
  assign ras_wr_idx  = ras_pop ? ras_top_idx : ras_ptr;
  assign e_jump_type = i_is_ret_e ? TYPE_RET : (i_is_call_e ? TYPE_CALL : TYPE_JUMP);
  assign f_target    = ((f_type == TYPE_RET) && (ras_cnt != '0)) ? ras_mem[ras_top_idx]
                                                                 : btb_target[f_btb_idx];
  assign unused_bits = ^i_pc_e[1:0];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else begin
      case ({ras_push, ras_pop})
        2'b10: begin
          ras_ptr <= ras_ptr + RAS_W'(1);
          if (ras_cnt != (RAS_W+1)'(RAS_DEPTH)) ras_cnt <= ras_cnt + (RAS_W+1)'(1);
        end
        2'b01: begin
          ras_ptr <= ras_top_idx;
          ras_cnt <= ras_cnt - (RAS_W+1)'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (ras_push) ras_mem[ras_wr_idx] <= i_pc_four_e;
  end
`else
  assign e_jump_type = TYPE_JUMP;
  assign f_target    = btb_target[f_btb_idx];
  assign unused_bits = ^{i_pc_e[1:0], i_is_call_e, i_is_ret_e};
`endif

  // Control state: valid bits, counters and history
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      btb_valid <= '0;
      bht       <= {BHT_ENTRIES{2'b01}};
      ghr       <= '0;
    end else begin
      if (e_btb_wr) btb_valid[e_btb_idx] <= 1'b1;
      if (e_branch_upd) begin
        bht[i_bht_idx_e] <= sat_step(bht[i_bht_idx_e], i_taken_e);
        ghr              <= GHR_BITS'({ghr, i_taken_e});
      end
    end
  end

  // BTB payload; only meaningful under a set valid bit
  always_ff @(posedge i_clk) begin
    if (e_btb_wr) begin
      btb_tag[e_btb_idx]    <= e_tag;
      btb_target[e_btb_idx] <= i_target_e;
      btb_type[e_btb_idx]   <= e_wr_type;
    end
  end

  assign o_pred_taken  = i_rst & f_taken;
  assign o_pred_target = o_pred_taken ? f_target : f_pc_plus4;
  assign o_bht_idx_f   = f_bht_idx;

  assign o_mispredict  = i_rst & i_vld_e &
                         ((i_taken_e != i_pred_taken_e) |
                          (i_taken_e & (i_target_e != i_pred_target_e)));
  assign o_redirect_pc = i_taken_e ? i_target_e : i_pc_four_e;

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Self-checking bench for branch_predictor_gshare: directed scenarios plus random resolves,
// compared against a table/queue model of the predictor rules.
module tb_branch_predictor_gshare;

`ifdef BP_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif
  localparam int RAS_N = 4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_pc_f;
  logic        o_pred_taken;
  logic [31:0] o_pred_target;
  logic [5:0]  o_bht_idx_f;
  logic        i_vld_e;
  logic [31:0] i_pc_e, i_pc_four_e, i_target_e, i_pred_target_e;
  logic        i_is_branch_e, i_is_jump_e, i_is_call_e, i_is_ret_e;
  logic        i_taken_e, i_pred_taken_e;
  logic [5:0]  i_bht_idx_e;
  logic        o_mispredict;
  logic [31:0] o_redirect_pc;

  int checks = 0;
  int errors = 0;

  branch_predictor_gshare dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_pc_f(i_pc_f),
    .o_pred_taken(o_pred_taken), .o_pred_target(o_pred_target), .o_bht_idx_f(o_bht_idx_f),
    .i_vld_e(i_vld_e), .i_pc_e(i_pc_e), .i_pc_four_e(i_pc_four_e),
    .i_is_branch_e(i_is_branch_e), .i_is_jump_e(i_is_jump_e),
    .i_is_call_e(i_is_call_e), .i_is_ret_e(i_is_ret_e),
    .i_taken_e(i_taken_e), .i_target_e(i_target_e),
    .i_pred_taken_e(i_pred_taken_e), .i_pred_target_e(i_pred_target_e),
    .i_bht_idx_e(i_bht_idx_e),
    .o_mispredict(o_mispredict), .o_redirect_pc(o_redirect_pc)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: BTB lines remember the full PC that owns them, the RAS is a plain queue.
  bit          m_vld   [16];
  logic [31:0] m_owner [16];
  logic [31:0] m_tgt   [16];
  int          m_kind  [16];
  int          m_cnt   [64];
  int          m_ghr;
  logic [31:0] m_ras [$];

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) m_vld[i] = 1'b0;
    for (int i = 0; i < 64; i++) m_cnt[i] = 1;
    m_ghr = 0;
    m_ras.delete();
  endfunction

  function automatic int m_bidx(logic [31:0] pc);
    return int'((pc >> 2) % 64) ^ m_ghr;
  endfunction

  function automatic int m_tidx(logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic void m_pred(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
    int  i;
    bit  hit;
    i   = m_tidx(pc);
    hit = m_vld[i] && ((m_owner[i] >> 2) == (pc >> 2));
    tk  = hit && (m_kind[i] != 0 || m_cnt[m_bidx(pc)] >= 2);
    if (!tk) tg = pc + 32'd4;
    else if (m_kind[i] == 3 && m_ras.size() > 0) tg = m_ras[m_ras.size()-1];
    else tg = m_tgt[i];
  endfunction

  function automatic void m_update();
    int c, i;
    if (!i_vld_e) return;
    if (i_is_branch_e) begin
      c = m_cnt[i_bht_idx_e];
      m_cnt[i_bht_idx_e] = i_taken_e ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
      m_ghr = ((m_ghr << 1) | int'(i_taken_e)) % 16;
    end
    if ((i_is_branch_e && i_taken_e) || i_is_jump_e) begin
      i = m_tidx(i_pc_e);
      m_vld[i]   = 1'b1;
      m_owner[i] = i_pc_e;
      m_tgt[i]   = i_target_e;
      if (!i_is_jump_e) m_kind[i] = 0;
      else if (RAS_EN && i_is_ret_e) m_kind[i] = 3;
      else if (RAS_EN && i_is_call_e) m_kind[i] = 2;
      else m_kind[i] = 1;
    end
    if (RAS_EN) begin
      if (i_is_ret_e && m_ras.size() > 0) void'(m_ras.pop_back());
      if (i_is_call_e) begin
        m_ras.push_back(i_pc_four_e);
        if (m_ras.size() > RAS_N) void'(m_ras.pop_front());
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic look(input string tag);
    logic        tk, mis;
    logic [31:0] tg, red;
    m_pred(i_pc_f, tk, tg);
    mis = i_vld_e && ((i_taken_e != i_pred_taken_e) || (i_taken_e && (i_target_e != i_pred_target_e)));
    red = i_taken_e ? i_target_e : i_pc_four_e;
    chk({tag, "_taken"},  32'(o_pred_taken), 32'(tk));
    chk({tag, "_target"}, o_pred_target, tg);
    chk({tag, "_idx"},    32'(o_bht_idx_f), 32'(m_bidx(i_pc_f)));
    chk({tag, "_mis"},    32'(o_mispredict), 32'(mis));
    chk({tag, "_redir"},  o_redirect_pc, red);
  endtask

  task automatic ex(input logic v, input logic [31:0] pc, input logic br, input logic jmp,
                    input logic call, input logic ret, input logic tk, input logic [31:0] tgt,
                    input logic ptk, input logic [31:0] ptg);
    i_vld_e = v; i_pc_e = pc; i_pc_four_e = pc + 32'd4;
    i_is_branch_e = br; i_is_jump_e = jmp; i_is_call_e = call; i_is_ret_e = ret;
    i_taken_e = tk; i_target_e = tgt; i_pred_taken_e = ptk; i_pred_target_e = ptg;
    i_bht_idx_e = 6'(m_bidx(pc));
  endtask

  task automatic idle();
    ex(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Resolve with the EX prediction fields taken from what the model would have predicted.
  task automatic ex_p(input logic [31:0] pc, input logic br, input logic jmp,
                      input logic call, input logic ret, input logic tk, input logic [31:0] tgt);
    logic        ptk;
    logic [31:0] ptg;
    m_pred(pc, ptk, ptg);
    ex(1'b1, pc, br, jmp, call, ret, tk, tgt, ptk, ptg);
  endtask

  task automatic tick();
    @(posedge i_clk);
    m_update();
    @(negedge i_clk);
  endtask

  task automatic step(input string tag);
    #1 look(tag);
    tick();
  endtask

  function automatic logic [31:0] rpc();
    return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 2);
  endfunction

  initial begin
    logic [5:0]  saved_idx;
    logic [31:0] pc_e, tgt, ptg;
    logic        br, jmp, call, ret, tk, ptk;
    int          r;

    i_rst = 1'b0;
    m_reset();
    i_pc_f = 32'h100;
    ex(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h5, 1'b0, 32'h0);
    #3;
    chk("in_reset_taken",  32'(o_pred_taken), 32'h0);
    chk("in_reset_target", o_pred_target, 32'h104);
    chk("in_reset_mis",    32'(o_mispredict), 32'h0);

    @(negedge i_clk);
    i_rst = 1'b1;
    idle();
    #1;
    chk("reset_taken",  32'(o_pred_taken), 32'h0);
    chk("reset_target", o_pred_target, 32'h104);
    chk("reset_idx",    32'(o_bht_idx_f), 32'h0);
    look("reset");
    tick();

    // Loop branch at 0x40 -> 0x20 resolved taken three times
    for (int k = 0; k < 3; k++) begin
      i_pc_f = 32'h40;
      ex_p(32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h20);
      step("loop_train");
    end
    idle();
    i_pc_f = 32'h40;
    step("loop_lookup");
    ex(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20, 1'b1, 32'h20);
    #1;
    chk("loop_exit_mis",   32'(o_mispredict), 32'h1);
    chk("loop_exit_redir", o_redirect_pc, 32'h44);
    look("loop_exit");
    tick();

    // Counter saturation: drive one counter up five times, then down once; it must still predict taken
    i_pc_f = 32'h78;
    ex_p(32'h78, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1000);
    step("sat_alloc");
    for (int k = 0; k < 5; k++) begin
      ex(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h20, 1'b1, 32'h20);
      i_bht_idx_e = 6'h10;
      step("sat_up");
    end
    ex(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20, 1'b1, 32'h20);
    i_bht_idx_e = 6'h10;
    step("sat_down");
    idle();
    i_pc_f = 32'h78;
    #1;
    chk("sat_idx",    32'(o_bht_idx_f), 32'h10);
    chk("sat_taken",  32'(o_pred_taken), 32'h1);
    chk("sat_target", o_pred_target, 32'h1000);
    look("sat");
    tick();

    // Jump allocation
    i_pc_f = 32'h80;
    ex(1'b1, 32'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'h84);
    #1;
    chk("jal_mis",   32'(o_mispredict), 32'h1);
    chk("jal_redir", o_redirect_pc, 32'h200);
    look("jal");
    tick();
    idle();
    #1;
    chk("jal_hit_taken",  32'(o_pred_taken), 32'h1);
    chk("jal_hit_target", o_pred_target, 32'h200);
    tick();

    // BTB aliasing: 0x40 and 0x80 share an index
    ex_p(32'h40, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h300);
    step("alias_a");
    ex_p(32'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h400);
    step("alias_b");
    idle();
    i_pc_f = 32'h40;
    #1;
    chk("alias_taken",  32'(o_pred_taken), 32'h0);
    chk("alias_target", o_pred_target, 32'h44);
    look("alias");
    tick();

    // Return stack: ret entry first, then five calls, then five returns
    i_pc_f = 32'h600;
    ex_p(32'h600, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h900);
    step("ret_alloc");
    for (int k = 0; k < 5; k++) begin
      ex_p(32'hC08, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h800);
      i_pc_four_e = 32'h104 + 32'(k) * 32'h100;
      step("call");
    end
    for (int k = 0; k < 5; k++) begin
      m_pred(32'h600, ptk, ptg);
      ex(1'b1, 32'h600, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, ptg, ptk, ptg);
      i_pc_f = 32'h600;
      #1;
      chk("ret_target", o_pred_target,
          (RAS_EN && k < 4) ? (32'h504 - 32'(k) * 32'h100) : ptg);
      look("ret");
      tick();
    end

    // Bubble: nothing may change and no flush is raised
    i_pc_f = 32'h80;
    ex(1'b0, 32'h80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h777, 1'b0, 32'h84);
    #1;
    chk("bubble_mis", 32'(o_mispredict), 32'h0);
    look("bubble");
    saved_idx = o_bht_idx_f;
    tick();
    idle();
    #1;
    chk("bubble_ghr", 32'(o_bht_idx_f), 32'(saved_idx));
    look("bubble_after");
    tick();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      i_pc_f = rpc();
      pc_e = rpc();
      tgt  = rpc();
      r    = int'($urandom_range(0, 9));
      br   = (r < 5);
      jmp  = (r >= 5 && r < 8);
      call = jmp && ($urandom_range(0, 2) == 0);
      ret  = jmp && ($urandom_range(0, 2) == 0);
      tk   = br ? 1'($urandom_range(0, 1)) : jmp;
      m_pred(pc_e, ptk, ptg);
      if ($urandom_range(0, 1) == 0) begin
        ptk = 1'($urandom_range(0, 1));
        ptg = rpc();
      end
      ex(($urandom_range(0, 7) != 0), pc_e, br, jmp, call, ret, tk, tgt, ptk, ptg);
      step("rand");
    end

    // Asynchronous reset mid-operation
    i_pc_f = 32'h80;
    ex(1'b1, 32'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h123, 1'b0, 32'h84);
    #2 i_rst = 1'b0;
    #1;
    chk("midrst_taken",  32'(o_pred_taken), 32'h0);
    chk("midrst_target", o_pred_target, 32'h84);
    chk("midrst_mis",    32'(o_mispredict), 32'h0);
    m_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    idle();
    #1;
    chk("postrst_taken", 32'(o_pred_taken), 32'h0);
    look("postrst");
    tick();
    for (int n = 0; n < 40; n++) begin
      i_pc_f = rpc();
      ex_p(rpc(), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), rpc());
      step("rand2");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
